// File: rtl/slot_arbiter.sv
// Phase-slot arbiter: hands one shared resource to 4 program contexts. The phase owner
// has priority in its slot, idle slots are lent round-robin, and grants are locked until release.
module slot_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [N_REQ-1:0] phase_in,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] done_in,
    output logic [N_REQ-1:0] gnt_out,
    output logic [1:0]       owner_out,
    output logic             busy_out,
    output logic             borrow_out,
    output logic             timeout_out,
    output logic             phase_err_out
);

    localparam int unsigned IDX_W = 2;
    // Last hold count before forced release; with the timeout disabled it is only the saturation point.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               borrow_q, borrow_d;
    logic               timeout_q, timeout_d;
    logic               perr_q, perr_d;

    logic               phase_ok;
    logic [IDX_W-1:0]   phase_k;
    logic [IDX_W-1:0]   cand;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               win_borrow;
    logic               holder_rel;

    // Winner selection: slot owner first, else round-robin from rr_q skipping the slot owner.
    always_comb begin
        phase_ok   = $onehot(phase_in);
        phase_k    = '0;
        cand       = '0;
        win_found  = 1'b0;
        win_idx    = '0;
        win_borrow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (phase_in[i]) phase_k = IDX_W'(i);
        end
        if (req_in[phase_k]) begin
            win_found = 1'b1;
            win_idx   = phase_k;
        end else begin
            // Walk offsets downward so the smallest offset from rr_q is the final assignment.
            for (int i = 3; i >= 0; i--) begin
                cand = rr_q + IDX_W'(i);
                if (cand != phase_k && req_in[cand]) begin
                    win_found  = 1'b1;
                    win_idx    = cand;
                    win_borrow = 1'b1;
                end
            end
        end
    end

    assign holder_rel = done_in[owner_q] || !req_in[owner_q];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        borrow_d  = borrow_q;
        timeout_d = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!phase_ok) begin
                    perr_d = 1'b1;
                end else if (win_found) begin
                    state_d  = S_GRANT;
                    gnt_d    = N_REQ'(1) << win_idx;
                    owner_d  = win_idx;
                    busy_d   = 1'b1;
                    borrow_d = win_borrow;
                    hold_d   = '0;
                    if (win_borrow) rr_d = win_idx + IDX_W'(1);
                end
            end
            S_GRANT: begin
                // Holder release outranks the hold-limit timeout.
                if (holder_rel) begin
                    state_d  = S_RELEASE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    borrow_d = 1'b0;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                    state_d   = S_RELEASE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    borrow_d  = 1'b0;
                    timeout_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                busy_d   = 1'b0;
                borrow_d = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                busy_d   = 1'b0;
                borrow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            borrow_q  <= 1'b0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            borrow_q  <= borrow_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
        end
    end

    assign gnt_out       = gnt_q;
    assign owner_out     = owner_q;
    assign busy_out      = busy_q;
    assign borrow_out    = borrow_q;
    assign timeout_out   = timeout_q;
    assign phase_err_out = perr_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// Bench for slot_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_slot_arbiter;

    localparam int MH = 4;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] phase_in, req_in, done_in;
    logic [3:0] gnt_out;
    logic [1:0] owner_out;
    logic       busy_out, borrow_out, timeout_out, phase_err_out;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: who holds the resource, for how long, and the lending pointer.
    int m_holder = -1;
    int m_age    = 0;
    int m_rr     = 0;
    int m_owner  = 0;
    bit m_gap    = 0;
    bit m_borrow = 0;
    bit m_to     = 0;
    bit m_perr   = 0;

    slot_arbiter #(.N_REQ(4), .MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .phase_in      (phase_in),
        .req_in        (req_in),
        .done_in       (done_in),
        .gnt_out       (gnt_out),
        .owner_out     (owner_out),
        .busy_out      (busy_out),
        .borrow_out    (borrow_out),
        .timeout_out   (timeout_out),
        .phase_err_out (phase_err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic void model_step(logic [3:0] ph, logic [3:0] rq, logic [3:0] dn, logic rs);
        int k;
        int w;
        bit brw;
        m_to   = 0;
        m_perr = 0;
        if (rs) begin
            m_holder = -1; m_age = 0; m_rr = 0; m_gap = 0; m_borrow = 0; m_owner = 0;
            return;
        end
        if (m_holder >= 0) begin
            if (dn[m_holder] || !rq[m_holder]) begin
                m_holder = -1; m_gap = 1; m_borrow = 0;
            end else if (m_age == MH - 1) begin
                m_holder = -1; m_gap = 1; m_borrow = 0; m_to = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if ($countones(ph) != 1) begin
            m_perr = 1;
        end else begin
            k = 0;
            for (int i = 0; i < 4; i++) if (ph[i]) k = i;
            w = -1;
            brw = 0;
            if (rq[k]) w = k;
            else begin
                for (int i = 0; i < 4 && w < 0; i++) begin
                    if ((m_rr + i) % 4 != k && rq[(m_rr + i) % 4]) begin
                        w = (m_rr + i) % 4;
                        brw = 1;
                    end
                end
            end
            if (w >= 0) begin
                m_holder = w; m_owner = w; m_age = 0; m_borrow = brw;
                if (brw) m_rr = (w + 1) % 4;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        model_step(phase_in, req_in, done_in, rst_in);
        #1;
    endtask

    task automatic settle();
        req_in = 4'b0000; done_in = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; phase_in = 4'b0001; req_in = 4'b0000; done_in = 4'b0000;
        repeat (2) tick();
        n_checks++; if (gnt_out !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_out); end
        n_checks++; if (owner_out !== 2'd0) begin n_errors++; $display("FAIL reset_owner got %0d exp 0", owner_out); end
        n_checks++; if ({busy_out, borrow_out, timeout_out, phase_err_out} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags got %b exp 0000", {busy_out, borrow_out, timeout_out, phase_err_out});
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_slot_ownership();
        phase_in = 4'b0010; req_in = 4'b0010;
        tick();
        n_checks++; if (gnt_out !== 4'b0010 || borrow_out !== 1'b0 || busy_out !== 1'b1) begin
            n_errors++; $display("FAIL own_grant got gnt=%b borrow=%b busy=%b exp 0010/0/1", gnt_out, borrow_out, busy_out);
        end
        n_checks++; if (owner_out !== 2'd1) begin n_errors++; $display("FAIL own_owner got %0d exp 1", owner_out); end
        done_in = 4'b0010;
        tick();
        done_in = 4'b0000;
        n_checks++; if (gnt_out !== 4'b0000 || busy_out !== 1'b0) begin
            n_errors++; $display("FAIL own_release got gnt=%b busy=%b exp 0000/0", gnt_out, busy_out);
        end
        tick();
        n_checks++; if (gnt_out !== 4'b0000) begin n_errors++; $display("FAIL own_dead got %b exp 0000", gnt_out); end
        req_in = 4'b0000;
        settle();
    endtask

    task automatic test_borrow_rr();
        phase_in = 4'b0001; req_in = 4'b1100;
        tick();
        n_checks++; if (gnt_out !== 4'b0100 || borrow_out !== 1'b1) begin
            n_errors++; $display("FAIL borrow_first got gnt=%b borrow=%b exp 0100/1", gnt_out, borrow_out);
        end
        done_in = 4'b0100;
        tick();
        done_in = 4'b0000;
        tick();
        tick();
        n_checks++; if (gnt_out !== 4'b1000 || borrow_out !== 1'b1 || owner_out !== 2'd3) begin
            n_errors++; $display("FAIL borrow_rr got gnt=%b borrow=%b owner=%0d exp 1000/1/3", gnt_out, borrow_out, owner_out);
        end
        settle();
    endtask

    task automatic test_timeout();
        int n;
        phase_in = 4'b0100; req_in = 4'b0100;
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_out === 4'b0100) n++; else break;
            tick();
        end
        n_checks++; if (n != MH) begin n_errors++; $display("FAIL to_hold_cycles got %0d exp %0d", n, MH); end
        n_checks++; if (timeout_out !== 1'b1 || gnt_out !== 4'b0000) begin
            n_errors++; $display("FAIL to_pulse got to=%b gnt=%b exp 1/0000", timeout_out, gnt_out);
        end
        tick();
        n_checks++; if (timeout_out !== 1'b0 || gnt_out !== 4'b0000) begin
            n_errors++; $display("FAIL to_gap got to=%b gnt=%b exp 0/0000", timeout_out, gnt_out);
        end
        tick();
        n_checks++; if (gnt_out !== 4'b0100) begin n_errors++; $display("FAIL to_rearb got %b exp 0100", gnt_out); end
        settle();
    endtask

    task automatic test_drop_and_simul();
        phase_in = 4'b0010; req_in = 4'b0010;
        tick(); tick();
        req_in = 4'b0000;
        tick();
        n_checks++; if (gnt_out !== 4'b0000 || timeout_out !== 1'b0) begin
            n_errors++; $display("FAIL drop_release got gnt=%b to=%b exp 0000/0", gnt_out, timeout_out);
        end
        tick();
        req_in = 4'b0010;
        tick();
        done_in = 4'b1101;
        tick();
        done_in = 4'b0000;
        n_checks++; if (gnt_out !== 4'b0010) begin n_errors++; $display("FAIL done_nonholder got %b exp 0010", gnt_out); end
        tick(); tick();
        done_in = 4'b0010;
        tick();
        done_in = 4'b0000;
        n_checks++; if (gnt_out !== 4'b0000 || timeout_out !== 1'b0) begin
            n_errors++; $display("FAIL done_vs_timeout got gnt=%b to=%b exp 0000/0", gnt_out, timeout_out);
        end
        settle();
    endtask

    task automatic test_phase_err();
        phase_in = 4'b0110; req_in = 4'b1111;
        tick();
        n_checks++; if (gnt_out !== 4'b0000 || phase_err_out !== 1'b1) begin
            n_errors++; $display("FAIL perr_flag got gnt=%b perr=%b exp 0000/1", gnt_out, phase_err_out);
        end
        phase_in = 4'b0100;
        tick();
        n_checks++; if (gnt_out !== 4'b0100 || phase_err_out !== 1'b0) begin
            n_errors++; $display("FAIL perr_recover got gnt=%b perr=%b exp 0100/0", gnt_out, phase_err_out);
        end
        settle();
    endtask

    task automatic test_reset_mid_grant();
        phase_in = 4'b0001; req_in = 4'b0100;
        tick();
        n_checks++; if (gnt_out !== 4'b0100) begin n_errors++; $display("FAIL rst_pre_borrow got %b exp 0100", gnt_out); end
        settle();
        req_in = 4'b0001;
        tick(); tick(); tick();
        n_checks++; if (gnt_out !== 4'b0001) begin n_errors++; $display("FAIL rst_pre_grant got %b exp 0001", gnt_out); end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_checks++; if ({gnt_out, busy_out, borrow_out, timeout_out, phase_err_out} !== 8'h00 || owner_out !== 2'd0) begin
            n_errors++; $display("FAIL rst_mid got gnt=%b flags=%b owner=%0d exp all 0", gnt_out,
                                 {busy_out, borrow_out, timeout_out, phase_err_out}, owner_out);
        end
        req_in = 4'b1010;
        tick();
        n_checks++; if (gnt_out !== 4'b0010 || borrow_out !== 1'b1) begin
            n_errors++; $display("FAIL rst_rr_cleared got gnt=%b borrow=%b exp 0010/1", gnt_out, borrow_out);
        end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] exp_gnt;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase_in = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'(1 << (cyc % 4));
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) req_in[b] = ~req_in[b];
            done_in = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            rst_in  = ($urandom_range(0, 299) == 0);
            tick();
            exp_gnt = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
            n_checks++; if (gnt_out !== exp_gnt || busy_out !== (m_holder >= 0)) begin
                n_errors++; $display("FAIL rand_gnt cyc %0d got gnt=%b busy=%b exp %b/%b", cyc, gnt_out, busy_out, exp_gnt, m_holder >= 0);
            end
            n_checks++; if (borrow_out !== m_borrow || timeout_out !== m_to || phase_err_out !== m_perr) begin
                n_errors++; $display("FAIL rand_flags cyc %0d got borrow=%b to=%b perr=%b exp %b/%b/%b", cyc,
                                     borrow_out, timeout_out, phase_err_out, m_borrow, m_to, m_perr);
            end
            if (m_holder >= 0) begin
                n_checks++; if (owner_out !== 2'(m_owner)) begin
                    n_errors++; $display("FAIL rand_owner cyc %0d got %0d exp %0d", cyc, owner_out, m_owner);
                end
            end
        end
        rst_in = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_slot_ownership();
        test_borrow_rr();
        test_timeout();
        test_drop_and_simul();
        test_phase_err();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/slot_arbiter.md
Name: slot_arbiter

Overview:
- Arbitrates one shared execution resource (e.g. a shared memory port or ALU) among 4 program contexts, using the one-hot phase slots from the 4-phase clock divider.
- The phase owner has priority in its slot. Unused slots are lent to other requesters in round-robin order (work-conserving).
- A grant is locked until the holder signals done, drops its request, or exceeds a hold limit.
- Sits between the clock divider, the four program engines and the shared resource mux.

Parameters:
- N_REQ, 4, number of requesters/slots; fixed at 4, with no other value supported.
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.
- CNT_W, 8, width of the hold counter; requires MAX_HOLD < 2^CNT_W.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- phase_in  input  4  one-hot slot indicator from the divider; bit k means slot k is owned by requester k.
- req_in  input  4  request per requester, level; held high while the requester wants or uses the resource.
- done_in  input  4  single-cycle completion strobe per requester.
- gnt_out  output  4  one-hot grant, registered.
- owner_out  output  2  index of the current grant holder; valid while busy_out=1.
- busy_out  output  1  high while any grant is active.
- borrow_out  output  1  high while the holder is not the phase owner of the slot in which it was granted.
- timeout_out  output  1  one-cycle pulse when a grant is force-released.
- phase_err_out  output  1  one-cycle pulse when phase_in was not one-hot during an IDLE arbitration cycle.

Behaviour:
- Reset (sampled on a rising clk_in edge with rst_in=1):
  - All outputs are 0, state=IDLE, rr_ptr=0, hold_cnt=0.
  - Reset during GRANT clears gnt_out at that same edge.
  - No timeout_out pulse is produced on reset.
- FSM states are IDLE, GRANT and RELEASE. The RELEASE state lasts exactly one cycle with gnt_out=0.
- IDLE, evaluated every edge:
  - If phase_in is not one-hot: no grant; phase_err_out=1 the next cycle; stay in IDLE.
  - Otherwise k = index of the set phase bit:
    - If req_in[k]=1, the winner is k and borrow=0.
    - Else the winner is the first set req_in bit, searching rr_ptr, rr_ptr+1, ... mod 4 and skipping k. In that case borrow=1 and rr_ptr becomes winner+1 mod 4.
    - If no request is set, stay in IDLE.
  - A winner moves the FSM to GRANT: gnt_out[winner]=1, owner_out=winner, busy_out=1, borrow_out=borrow, hold_cnt=0.
- Latency: a request sampled at edge N gives a grant visible after edge N (1 cycle). rr_ptr is unchanged on owner grants.
- GRANT, each edge, in priority order:
  1. done_in[owner]=1 or req_in[owner]=0 → RELEASE.
  2. Else, if MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 → RELEASE with timeout_out=1 for one cycle.
  3. Else hold_cnt increments (saturating at MAX_HOLD-1).
  - done_in on non-holder bits is ignored.
  - phase_in changes during GRANT are ignored; there is no preemption.
- Done and timeout on the same edge: the done release wins and timeout_out stays 0.
- RELEASE: gnt_out=0, busy_out=0, borrow_out=0; return to IDLE. The next arbitration happens on the following edge, giving a guaranteed 1-cycle dead gap between grants.
- gnt_out is never more than one-hot. owner_out holds its last value when idle; the verifier must ignore it when busy_out=0.

Test Plan:
1. Slot ownership: phase_in=0010 (k=1), req_in=0010. Required: gnt_out=0010 one cycle later, borrow_out=0. Then done_in=0010 → gnt_out=0000 on the next cycle and 1 dead cycle follows.
2. Borrow and round-robin: phase_in=0001, req_in=1100, rr_ptr=0. Required: grant 0100 with borrow_out=1, rr_ptr=3. After release, with phase_in=0001 and req_in=1100 again, the grant is 1000 and rr_ptr=0.
3. Timeout: MAX_HOLD=4, grant to req 2, done never asserted. Required: gnt_out high for exactly 4 cycles, then timeout_out pulses 1 cycle, then the gap cycle, then re-arbitration.
4. Request drop and simultaneous events:
   - Holder drops req_in mid-grant → release with timeout_out=0.
   - done_in on the same edge as hold_cnt==MAX_HOLD-1 → timeout_out=0.
   - done_in on a non-holder → no effect.
5. Phase error: phase_in=0110 with req_in=1111 while IDLE. Required: no grant, phase_err_out=1 for 1 cycle. Then phase_in=0100 → gnt_out=0100.
6. Reset mid-grant: rst_in=1 while gnt_out=0001 and hold_cnt=2. Required: all outputs 0 after that edge, rr_ptr=0, and the first arbitration after rst_in falls is the normal 1-cycle path.
